// File: rtl/reg_rd_pkg.sv
// reg_rd_pkg: shared constants and types for the register read-back sequencer.
//   NUM_REGS   number of registers in the flattened register file
//   ADDR_W     width of a register index
//   LEN_W      width of the burst-length-minus-one field
//   rd_state_t sequencer state (IDLE, SEND)
package reg_rd_pkg;

   localparam int unsigned NUM_REGS = 16;
   localparam int unsigned ADDR_W   = 4;
   localparam int unsigned LEN_W    = 4;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } rd_state_t;

endpackage

// File: rtl/reg_word_mux.sv
// reg_word_mux: combinational 16:1 word select from a flattened register file.
//   regs_i  NUM_REGS*DATA_W flattened registers, register i at [i*DATA_W +: DATA_W]
//   idx_i   register index to select
//   word_o  selected register word
module reg_word_mux
   import reg_rd_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic [NUM_REGS*DATA_W-1:0] regs_i,
   input  logic [ADDR_W-1:0]          idx_i,
   output logic [DATA_W-1:0]          word_o
);

   always_comb begin
      word_o = '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         if (idx_i == ADDR_W'(i)) begin
            word_o = regs_i[i*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/reg_read_seq.sv
// reg_read_seq: register read-back sequencer. Accepts a read command (start address plus
// burst length minus one), snapshots the addressed registers one word at a time and streams
// them out over a valid/ready handshake.
//   clk              system clock, rising edge
//   reset            synchronous active-high reset
//   strob_in         read command strobe
//   choose_data_reg  marks strob_in as a data-phase strobe (never a read command)
//   addr_in          start register index
//   len_in           burst length minus one
//   regs_in          flattened register file
//   data_out         current read word (snapshot taken at load)
//   addr_out         register index of data_out
//   data_valid_out   data_out/addr_out valid
//   data_ready_in    downstream accepts the word when high with data_valid_out
//   busy_out         burst in progress
//   done_out         one-cycle pulse after the last word is accepted
//   overrun_out      sticky flag: a command arrived while busy
module reg_read_seq
   import reg_rd_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       strob_in,
   input  logic                       choose_data_reg,
   input  logic [ADDR_W-1:0]          addr_in,
   input  logic [LEN_W-1:0]           len_in,
   input  logic [NUM_REGS*DATA_W-1:0] regs_in,
   output logic [DATA_W-1:0]          data_out,
   output logic [ADDR_W-1:0]          addr_out,
   output logic                       data_valid_out,
   input  logic                       data_ready_in,
   output logic                       busy_out,
   output logic                       done_out,
   output logic                       overrun_out
);

   rd_state_t          state_q, state_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [LEN_W-1:0]   rem_q, rem_d;
   logic               valid_q, valid_d;
   logic               done_q, done_d;
   logic               ovr_q, ovr_d;

   logic               cmd;
   logic [ADDR_W-1:0]  addr_nxt;
   logic [ADDR_W-1:0]  mux_idx;
   logic [DATA_W-1:0]  mux_word;

   assign cmd      = strob_in & ~choose_data_reg;
   assign addr_nxt = addr_q + ADDR_W'(1);  // wraps 15 -> 0
   // In IDLE the mux serves the first word of a new burst; in SEND it prefetches the next one.
   assign mux_idx  = (state_q == IDLE) ? addr_in : addr_nxt;

   reg_word_mux #(
      .DATA_W (DATA_W)
   ) u_word_mux (
      .regs_i (regs_in),
      .idx_i  (mux_idx),
      .word_o (mux_word)
   );

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      ovr_d   = ovr_q;
      unique case (state_q)
         IDLE: begin
            if (cmd) begin
               state_d = SEND;
               data_d  = mux_word;
               addr_d  = addr_in;
               rem_d   = len_in;
               valid_d = 1'b1;
               ovr_d   = 1'b0;
            end
         end
         SEND: begin
            if (cmd) begin
               ovr_d = 1'b1;
            end
            if (data_ready_in) begin
               if (rem_q != '0) begin
                  data_d = mux_word;
                  addr_d = addr_nxt;
                  rem_d  = rem_q - LEN_W'(1);
               end else begin
                  // Last word accepted: data/addr keep their final values.
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         data_q  <= '0;
         addr_q  <= '0;
         rem_q   <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
      end
   end

   assign data_out       = data_q;
   assign addr_out       = addr_q;
   assign data_valid_out = valid_q;
   assign busy_out       = (state_q == SEND);
   assign done_out       = done_q;
   assign overrun_out    = ovr_q;

endmodule

// File: tb/tb_reg_read_seq.sv
// tb_reg_read_seq: self-checking bench for reg_read_seq. Each burst is checked against a
// word-level model: word k of a burst carries address (start+k) mod 16 and the register value
// present on the edge it was loaded (the command edge for word 0, the previous handshake edge
// for the rest).
module tb_reg_read_seq;

   logic         clk = 1'b0;
   logic         reset;
   logic         strob_in;
   logic         choose_data_reg;
   logic [3:0]   addr_in;
   logic [3:0]   len_in;
   logic [127:0] regs_in;
   logic [7:0]   data_out;
   logic [3:0]   addr_out;
   logic         data_valid_out;
   logic         data_ready_in;
   logic         busy_out;
   logic         done_out;
   logic         overrun_out;

   int n_cmp = 0;
   int n_bad = 0;
   bit exp_ovr = 1'b0;
   int ready_pat[$];

   reg_read_seq #(
      .DATA_W (8)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .strob_in        (strob_in),
      .choose_data_reg (choose_data_reg),
      .addr_in         (addr_in),
      .len_in          (len_in),
      .regs_in         (regs_in),
      .data_out        (data_out),
      .addr_out        (addr_out),
      .data_valid_out  (data_valid_out),
      .data_ready_in   (data_ready_in),
      .busy_out        (busy_out),
      .done_out        (done_out),
      .overrun_out     (overrun_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] reg_word(input int idx);
      return regs_in[(idx % 16)*8 +: 8];
   endfunction

   // Status view used by all checks: {valid, busy, done, overrun}.
   function automatic logic [3:0] status();
      return {data_valid_out, busy_out, done_out, overrun_out};
   endfunction

   // Runs one burst. ready_pct sets the chance of ready per cycle once ready_pat is drained;
   // scramble rewrites regs_in on stall cycles; inject >= 0 places a strobe at that word;
   // chain leaves the bench in the done cycle so the caller can issue the next command there.
   task automatic do_burst(input string name, input int start, input int len,
                           input int ready_pct, input bit scramble, input int inject,
                           input bit chain);
      logic [7:0] exp_data, nxt_data;
      int         k = 0;
      int         cycles = 0;
      bit         ready, ovr_pend;
      strob_in        = 1'b1;
      choose_data_reg = 1'b0;
      addr_in         = 4'(start);
      len_in          = 4'(len);
      data_ready_in   = 1'b0;
      exp_data        = reg_word(start);
      exp_ovr         = 1'b0;
      tick();
      while (k <= len) begin
         if (status() !== {3'b110, exp_ovr} || addr_out !== 4'((start + k) % 16) ||
             data_out !== exp_data) begin
            $display("FAIL %s word %0d: got st=%b addr=%0d data=%h, want st=%b addr=%0d data=%h",
                     name, k, status(), addr_out, data_out, {3'b110, exp_ovr},
                     (start + k) % 16, exp_data);
            n_bad++;
         end
         n_cmp++;
         strob_in        = 1'b0;
         choose_data_reg = 1'b0;
         ovr_pend        = 1'b0;
         if (k == inject) begin
            inject          = -1;
            strob_in        = 1'b1;
            choose_data_reg = 1'($urandom_range(1));
            addr_in         = 4'($urandom);
            len_in          = 4'($urandom);
            ovr_pend        = !choose_data_reg;
         end
         if (ready_pat.size() > 0) ready = ready_pat.pop_front() != 0;
         else ready = ($urandom_range(99) < ready_pct);
         data_ready_in = ready;
         if (scramble && !ready) regs_in = {$urandom, $urandom, $urandom, $urandom};
         nxt_data = reg_word(start + k + 1);
         tick();
         cycles++;
         if (ovr_pend) exp_ovr = 1'b1;
         if (ready) begin
            if (k < len) exp_data = nxt_data;
            k++;
         end
         if (cycles > 300) begin
            $display("FAIL %s timeout: %0d of %0d words accepted", name, k, len + 1);
            n_bad++;
            n_cmp++;
            break;
         end
      end
      strob_in      = 1'b0;
      data_ready_in = 1'b0;
      if (status() !== {3'b001, exp_ovr} || addr_out !== 4'((start + len) % 16) ||
          data_out !== exp_data) begin
         $display("FAIL %s done: got st=%b addr=%0d data=%h, want st=%b addr=%0d data=%h",
                  name, status(), addr_out, data_out, {3'b001, exp_ovr}, (start + len) % 16,
                  exp_data);
         n_bad++;
      end
      n_cmp++;
      if (!chain) begin
         tick();
         if (status() !== {3'b000, exp_ovr}) begin
            $display("FAIL %s after done: got st=%b, want st=%b", name, status(),
                     {3'b000, exp_ovr});
            n_bad++;
         end
         n_cmp++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      if ({status(), addr_out, data_out} !== 16'h0000) begin
         $display("FAIL reset: got st=%b addr=%0d data=%h, want all 0", status(), addr_out,
                  data_out);
         n_bad++;
      end
      n_cmp++;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single();
      regs_in[5*8 +: 8] = 8'hA5;
      do_burst("single", 5, 0, 100, 1'b0, -1, 1'b0);
      if (data_out !== 8'hA5) begin
         $display("FAIL single value: got %h, want a5", data_out);
         n_bad++;
      end
      n_cmp++;
   endtask

   task automatic test_wrap();
      do_burst("wrap", 14, 2, 100, 1'b0, -1, 1'b0);
   endtask

   task automatic test_backpressure();
      ready_pat = '{1, 0, 0, 1, 1, 0, 1};
      do_burst("backpressure", 0, 3, 100, 1'b1, -1, 1'b0);
      if (ready_pat.size() != 0) begin
         $display("FAIL backpressure pattern: %0d ready entries unused, want 0", ready_pat.size());
         n_bad++;
      end
      n_cmp++;
   endtask

   task automatic test_filter_overrun();
      // Data-phase strobe with ready high in IDLE must do nothing.
      strob_in        = 1'b1;
      choose_data_reg = 1'b1;
      data_ready_in   = 1'b1;
      tick();
      tick();
      if (status() !== 4'b0000) begin
         $display("FAIL filter idle: got st=%b, want 0000", status());
         n_bad++;
      end
      n_cmp++;
      strob_in = 1'b0;
      data_ready_in = 1'b0;
      // Retry until the injected strobe is a real command so overrun is exercised.
      do begin
         do_burst("overrun", 3, 5, 70, 1'b0, 2, 1'b0);
      end while (!exp_ovr);
      strob_in        = 1'b1;
      choose_data_reg = 1'b1;
      tick();
      strob_in = 1'b0;
      if (status() !== 4'b0001) begin
         $display("FAIL overrun sticky: got st=%b, want 0001", status());
         n_bad++;
      end
      n_cmp++;
      do_burst("overrun clear", 9, 1, 100, 1'b0, -1, 1'b0);
   endtask

   task automatic test_back_to_back();
      do_burst("b2b first", 12, 3, 100, 1'b0, -1, 1'b1);
      do_burst("b2b second", 1, 2, 100, 1'b0, -1, 1'b0);
   endtask

   task automatic test_reset_mid_burst();
      strob_in        = 1'b1;
      choose_data_reg = 1'b0;
      addr_in         = 4'd10;
      len_in          = 4'd7;
      data_ready_in   = 1'b1;
      tick();
      strob_in = 1'b0;
      tick();
      if (addr_out !== 4'd11 || data_out !== reg_word(11)) begin
         $display("FAIL reset mid word2: got addr=%0d data=%h, want addr=11 data=%h", addr_out,
                  data_out, reg_word(11));
         n_bad++;
      end
      n_cmp++;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      if ({status(), addr_out, data_out} !== 16'h0000) begin
         $display("FAIL reset mid burst: got st=%b addr=%0d data=%h, want all 0", status(),
                  addr_out, data_out);
         n_bad++;
      end
      n_cmp++;
      tick();
      if (status() !== 4'b0000) begin
         $display("FAIL reset no done: got st=%b, want 0000", status());
         n_bad++;
      end
      n_cmp++;
      data_ready_in = 1'b0;
      do_burst("after reset", 4, 2, 100, 1'b0, -1, 1'b0);
   endtask

   task automatic test_full_sweep();
      regs_in = {$urandom, $urandom, $urandom, $urandom};
      do_burst("sweep", 7, 15, 100, 1'b0, -1, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 25; i++) begin
         regs_in = {$urandom, $urandom, $urandom, $urandom};
         do_burst("random", int'($urandom_range(15)), int'($urandom_range(15)),
                  int'($urandom_range(90, 30)), 1'b1,
                  ($urandom_range(1) != 0) ? int'($urandom_range(3)) : -1,
                  ($urandom_range(1) != 0));
      end
   endtask

   initial begin
      reset           = 1'b1;
      strob_in        = 1'b0;
      choose_data_reg = 1'b0;
      addr_in         = '0;
      len_in          = '0;
      data_ready_in   = 1'b0;
      regs_in         = {$urandom, $urandom, $urandom, $urandom};
      test_reset();
      test_single();
      test_wrap();
      test_backpressure();
      test_filter_overrun();
      test_back_to_back();
      test_reset_mid_burst();
      test_full_sweep();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/reg_read_seq.md
# reg_read_seq

Register read-back sequencer: the read-side counterpart of the 16-entry register-file write-strobe decoder. It accepts a read command (4-bit start address plus burst length) in the same strobe/address format the write decoder uses. It snapshots the addressed registers one word at a time from the flattened register bus and streams them out over a valid/ready handshake. It sits between the command front end and the outbound data path, alongside the write decoder, on the same clock.

## Interface
- DATA_W, 8, width of one register word
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- strob_in  input  1  read command strobe, sampled on clk
- choose_data_reg  input  1  when high, strob_in is a data-phase strobe and is not a read command
- addr_in  input  4  start register index, 0..15
- len_in  input  4  burst length minus one (0 = 1 word, 15 = 16 words)
- regs_in  input  16*DATA_W  flattened register file; register i at bits [i*DATA_W +: DATA_W]
- data_out  output  DATA_W  current read word
- addr_out  output  4  register index of data_out
- data_valid_out  output  1  data_out/addr_out valid
- data_ready_in  input  1  downstream accepts the word when high together with data_valid_out
- busy_out  output  1  burst in progress
- done_out  output  1  one-cycle pulse after the last word of a burst is accepted
- overrun_out  output  1  sticky: a command arrived while busy

## Operation
- Command accepted when strob_in & !choose_data_reg & state==IDLE.
- States: IDLE, SEND.
- IDLE -> SEND on an accepted command. The same edge loads:
  - data_out <= regs_in[addr_in]
  - addr_out <= addr_in
  - remaining <= len_in
  - data_valid_out <= 1
  - overrun_out <= 0
- SEND, data_ready_in=0: all outputs hold. data_out does not follow later regs_in changes; the word is a snapshot taken at load.
- SEND, data_ready_in=1, remaining!=0: load the next word the same edge, with no bubble:
  - addr_out <= addr_out+1, wrapping 15 -> 0
  - data_out <= regs_in[addr_out+1]
  - remaining <= remaining-1
  - data_valid_out stays 1
- SEND, data_ready_in=1, remaining==0:
  - data_valid_out <= 0, done_out <= 1 for one cycle, state <= IDLE.
  - addr_out and data_out hold their last values.
- busy_out = (state==SEND), registered.
- strob_in & !choose_data_reg while in SEND:
  - The command is ignored and overrun_out <= 1.
  - overrun_out stays set until reset or the next accepted command.
- strob_in with choose_data_reg=1: ignored in every state and has no effect on overrun_out.
- Address arithmetic is 4-bit modulo 16. len_in=15 from any start reads all 16 registers exactly once.

## Timing
- Reset values:
  - state IDLE
  - data_out 0, addr_out 0
  - data_valid_out 0, busy_out 0, done_out 0, overrun_out 0
- Reset is synchronous and dominates every other input. A reset during SEND aborts the burst next edge with no done_out pulse.
- Latency:
  - Accepted command at edge N: data_valid_out=1 and the first word present after edge N.
  - Subsequent words follow one per cycle while data_ready_in=1.
- Burst of L=len_in+1 words with ready held high: valid high for exactly L cycles, then done_out high for 1 cycle, with busy_out low in that same cycle.
- A new command is accepted at earliest the edge on which done_out is high, i.e. the first cycle state==IDLE.
- data_ready_in may be driven high while data_valid_out=0; it has no effect.
- Once data_valid_out is raised, data_out and addr_out remain stable until the handshake.

## Structure
- Package reg_rd_pkg holds:
  - NUM_REGS=16, ADDR_W=4, LEN_W=4
  - state enum rd_state_t {IDLE, SEND}
- Sub-module reg_word_mux: combinational DATA_W-wide 16:1 select of regs_in by a 4-bit index. The top instantiates one, indexed by (state==IDLE ? addr_in : addr_out+1).
- Top holds the state register, the remaining counter, the output registers and the overrun flag.

## Test plan
- Single read: regs[5]=0xA5, strob_in=1, addr_in=5, len_in=0, ready=1.
  - Next cycle: data_out=0xA5, addr_out=5, valid=1.
  - Following cycle: done_out=1, valid=0.
- Wrap burst: addr_in=14, len_in=2, ready=1.
  - Words are regs[14], regs[15], regs[0] on 3 consecutive cycles, addr_out 14,15,0.
  - Then done_out pulse.
- Backpressure: 4-word burst from 0 with ready toggling 1,0,0,1,1,0,1.
  - Each word held stable while ready=0, and regs_in changes during the stall do not alter data_out.
  - Exactly 4 handshakes, then done.
- Filtering and overrun:
  - strob_in with choose_data_reg=1 in IDLE: no response.
  - strob_in with choose_data_reg=0 mid-burst: overrun_out=1 and the burst continues unchanged.
  - The next accepted command clears overrun_out.
- Reset mid-burst: assert reset during word 2 of 8.
  - Next cycle all outputs are 0, with no done_out.
  - A new command 2 cycles later is served normally.
- Full sweep: addr_in=7, len_in=15 with ready=1.
  - 16 words, addresses 7..15,0..6, each matching regs_in.
